pe_requant: RTL and testbench

Output-side requantizer for the PE array: consumes signed 32-bit accumulator results and produces uint8 activations for the next layer's ifmap buffer. It is the inverse-direction partner of the PE multiplier, which takes uint8 ifmap × int8 weight to int32. It adds a per-element bias, applies a fixed-point scale (multiply, then rounding right shift), adds a zero point, and saturates to [0,255]. It is a 3-stage valid/ready pipeline with full backpressure, a static configuration port, and an output counter.

---
 rtl/pe_requant.sv | 164 ++++++++++++++++
 tb/tb_pe_requant.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_requant.sv
// Requantizer: int32 accumulator + bias -> scaled, rounded, zero-pointed, saturated uint8.
// Latency: 3 cycles from acceptance to out_valid. Throughput is 1 element per cycle.
// Backpressure: combinational ready chain from out_ready, with no bubble. A stalled output holds stable.
//
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   in_valid/in_ready                 input handshake
//   in_acc, in_bias, in_last          element payload
//   out_valid/out_ready               output handshake
//   out_data, out_last                uint8 activation and tile-end marker
//   cfg_we, cfg_mult, cfg_shift, cfg_zp   static config, honoured only while idle
//   busy                              pipeline holds data or is accepting an element
//   out_count                         transfers since reset or the last applied cfg write
module pe_requant #(
    parameter int ACC_W  = 32,
    parameter int MULT_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ACC_W-1:0]  in_acc,
    input  logic [ACC_W-1:0]  in_bias,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_data,
    output logic              out_last,
    input  logic              cfg_we,
    input  logic [MULT_W-1:0] cfg_mult,
    input  logic [4:0]        cfg_shift,
    input  logic [7:0]        cfg_zp,
    output logic              busy,
    output logic [CNT_W-1:0]  out_count
);

    localparam int SUM_W  = ACC_W + 1;            // acc + bias never wraps
    localparam int PROD_W = SUM_W + MULT_W + 1;   // signed sum times unsigned mult
    localparam int RND_W  = PROD_W + 2;           // headroom for rounding add and zero point

    // Configuration
    logic [MULT_W-1:0] cfg_mult_q;
    logic [4:0]        cfg_shift_q;
    logic [7:0]        cfg_zp_q;

    // Pipeline state
    logic                     s1_vld, s2_vld, s3_vld;
    logic                     s1_last, s2_last, s3_last;
    logic signed [SUM_W-1:0]  s1_sum;
    logic signed [PROD_W-1:0] s2_prod;
    logic [7:0]               s3_dat;

    logic adv1, adv2, adv3;
    logic in_fire, out_fire, cfg_apply;

    logic signed [SUM_W-1:0]  sum_nxt;
    logic signed [PROD_W-1:0] prod_nxt;
    logic signed [RND_W-1:0]  p_ext, rnd_bias, rounded, v;
    logic [7:0]               sat_nxt;

    // A stage may load when it is empty or when its contents move on this cycle.
    assign adv3      = !s3_vld || out_ready;
    assign adv2      = !s2_vld || adv3;
    assign adv1      = !s1_vld || adv2;
    assign in_ready  = adv1;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = s3_vld && out_ready;
    assign busy      = s1_vld || s2_vld || s3_vld || in_fire;
    // Config only changes with the pipeline empty, so no element sees a mix.
    assign cfg_apply = cfg_we && !busy;

    assign out_valid = s3_vld;
    assign out_data  = s3_dat;
    assign out_last  = s3_last;

    always_comb begin
        sum_nxt  = $signed({in_acc[ACC_W-1], in_acc}) + $signed({in_bias[ACC_W-1], in_bias});
        prod_nxt = $signed({{(PROD_W-SUM_W){s1_sum[SUM_W-1]}}, s1_sum})
                 * $signed({{(PROD_W-MULT_W){1'b0}}, cfg_mult_q});
    end

    // Rounding: add half an LSB of the result, then arithmetic shift, so ties go to +inf.
    // With shift=0 the half-LSB term is zero and the shift is a no-op.
    always_comb begin
        p_ext    = {{(RND_W-PROD_W){s2_prod[PROD_W-1]}}, s2_prod};
        rnd_bias = (RND_W'(1) << cfg_shift_q) >>> 1;
        rounded  = (p_ext + rnd_bias) >>> cfg_shift_q;
        v        = rounded + $signed({{(RND_W-8){1'b0}}, cfg_zp_q});
        sat_nxt  = v[7:0];
        if (v[RND_W-1]) begin
            sat_nxt = 8'd0;
        end else if (|v[RND_W-2:8]) begin
            sat_nxt = 8'd255;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_mult_q  <= MULT_W'(1);
            cfg_shift_q <= 5'd0;
            cfg_zp_q    <= 8'd0;
        end else if (cfg_apply) begin
            cfg_mult_q  <= cfg_mult;
            cfg_shift_q <= cfg_shift;
            cfg_zp_q    <= cfg_zp;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld  <= 1'b0;
            s1_last <= 1'b0;
            s1_sum  <= '0;
        end else if (adv1) begin
            s1_vld <= in_valid;
            if (in_valid) begin
                s1_sum  <= sum_nxt;
                s1_last <= in_last;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_vld  <= 1'b0;
            s2_last <= 1'b0;
            s2_prod <= '0;
        end else if (adv2) begin
            s2_vld <= s1_vld;
            if (s1_vld) begin
                s2_prod <= prod_nxt;
                s2_last <= s1_last;
            end
        end
    end

    // The output register only reloads when the previous result has gone,
    // which keeps out_data/out_last stable during a stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s3_vld  <= 1'b0;
            s3_last <= 1'b0;
            s3_dat  <= 8'd0;
        end else if (adv3) begin
            s3_vld <= s2_vld;
            if (s2_vld) begin
                s3_dat  <= sat_nxt;
                s3_last <= s2_last;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_count <= '0;
        end else if (cfg_apply) begin
            out_count <= '0;
        end else if (out_fire) begin
            out_count <= out_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pe_requant.sv
module tb_pe_requant;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_acc;
    logic [31:0] in_bias;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_last;
    logic        cfg_we;
    logic [15:0] cfg_mult;
    logic [4:0]  cfg_shift;
    logic [7:0]  cfg_zp;
    logic        busy;
    logic [15:0] out_count;

    int checks   = 0;
    int failures = 0;

    pe_requant dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_acc    (in_acc),
        .in_bias   (in_bias),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .cfg_we    (cfg_we),
        .cfg_mult  (cfg_mult),
        .cfg_shift (cfg_shift),
        .cfg_zp    (cfg_zp),
        .busy      (busy),
        .out_count (out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Write config at one edge; it is applied only if the block is idle.
    task automatic cfg(input logic [15:0] m, input logic [4:0] s, input logic [7:0] z);
        @(negedge clk);
        cfg_we = 1'b1; cfg_mult = m; cfg_shift = s; cfg_zp = z;
        @(posedge clk);
        #1 cfg_we = 1'b0;
    endtask

    // Present one element for exactly one edge (caller guarantees space).
    task automatic send(input logic [31:0] acc, input logic [31:0] bias, input logic last, input string tag);
        @(negedge clk);
        in_valid = 1'b1; in_acc = acc; in_bias = bias; in_last = last;
        #1 check({tag, "_in_ready"}, in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Wait (bounded) for an output, check it; the transfer happens at the following edge.
    task automatic recv(input logic [7:0] exp, input string tag);
        int n;
        n = 0;
        @(negedge clk);
        out_ready = 1'b1;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_vld"}, out_valid, 1);
        check(tag, out_data, exp);
    endtask

    initial begin
        int pat[8] = '{1, 0, 0, 1, 0, 1, 1, 0};
        int sent, rcv, infl, cyc, acc_f, out_f;
        logic       stall_prev;
        logic [7:0] d_prev;
        logic       l_prev;

        rst_n = 1'b0; in_valid = 1'b0; in_acc = '0; in_bias = '0; in_last = 1'b0;
        out_ready = 1'b0; cfg_we = 1'b0; cfg_mult = '0; cfg_shift = '0; cfg_zp = '0;

        // Reset state
        #12;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_out_count", out_count, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Defaults and 3-cycle latency: 100 + 27 = 127
        cfg(16'd1, 5'd0, 8'd0);
        @(negedge clk);
        in_valid = 1'b1; in_acc = 32'd100; in_bias = 32'd27; in_last = 1'b0; out_ready = 1'b1;
        #1;
        check("lat_in_ready", in_ready, 1);
        check("lat_busy_accept", busy, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("lat_vld_e1", out_valid, 0);
        @(negedge clk);
        check("lat_vld_e2", out_valid, 0);
        @(negedge clk);
        check("lat_vld_e3", out_valid, 1);
        check("lat_data", out_data, 127);
        check("lat_last", out_last, 0);
        @(negedge clk);
        check("lat_count", out_count, 1);
        check("lat_idle_vld", out_valid, 0);
        check("lat_idle_busy", busy, 0);

        // Rounding and zero point: mult=3 shift=2 zp=10
        cfg(16'd3, 5'd2, 8'd10);
        send(32'd5, 32'd0, 1'b0, "rnd_p5");
        recv(8'd14, "rnd_p5");
        send(-32'sd5, 32'd0, 1'b0, "rnd_m5");
        recv(8'd6, "rnd_m5");
        send(32'd2, 32'd0, 1'b0, "rnd_tie");
        recv(8'd12, "rnd_tie");

        // Saturation
        cfg(16'd1, 5'd0, 8'd0);
        send(32'd1000, 32'd0, 1'b0, "sat_hi");
        recv(8'd255, "sat_hi");
        send(-32'sd1000, 32'd0, 1'b0, "sat_lo");
        recv(8'd0, "sat_lo");
        send(32'd255, 32'd0, 1'b0, "sat_edge");
        recv(8'd255, "sat_edge");
        send(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, "sat_nowrap_pos");
        recv(8'd255, "sat_nowrap_pos");
        send(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "sat_nowrap_neg");
        recv(8'd0, "sat_nowrap_neg");
        cfg(16'd65535, 5'd31, 8'd0);
        send(32'h7FFF_FFFF, 32'd0, 1'b0, "sat_bigmult");
        recv(8'd255, "sat_bigmult");

        // Backpressure stream
        cfg(16'd1, 5'd0, 8'd0);
        sent = 0; rcv = 0; infl = 0; cyc = 0; stall_prev = 1'b0; d_prev = '0; l_prev = 1'b0;
        while (rcv < 8 && cyc < 200) begin
            @(negedge clk);
            if (stall_prev) begin
                check("bp_hold_vld", out_valid, 1);
                check("bp_hold_dat", out_data, d_prev);
                check("bp_hold_last", out_last, l_prev);
            end
            out_ready = (pat[cyc % 8] != 0);
            in_valid  = (sent < 8);
            in_acc    = 32'(sent + 1);
            in_bias   = '0;
            in_last   = (sent == 7);
            #1;
            if (infl == 3 && !out_ready) check("bp_full_rdy", in_ready, 0);
            acc_f = (in_valid && in_ready) ? 1 : 0;
            out_f = (out_valid && out_ready) ? 1 : 0;
            if (out_f == 1) begin
                check("bp_order", out_data, rcv + 1);
                check("bp_last", out_last, (rcv == 7) ? 1 : 0);
                rcv++;
            end
            stall_prev = out_valid && !out_ready;
            d_prev = out_data;
            l_prev = out_last;
            infl = infl + acc_f - out_f;
            sent = sent + acc_f;
            cyc++;
            @(posedge clk);
        end
        in_valid = 1'b0; in_last = 1'b0;
        check("bp_all_received", rcv, 8);
        @(negedge clk);
        check("bp_count", out_count, 8);

        // Config guard: write dropped while busy
        cfg(16'd1, 5'd0, 8'd0);
        out_ready = 1'b0;
        send(32'd32, 32'd0, 1'b0, "grd_a");
        send(32'd48, 32'd0, 1'b0, "grd_b");
        @(negedge clk);
        cfg_we = 1'b1; cfg_mult = 16'd1; cfg_shift = 5'd4; cfg_zp = 8'd0;
        #1 check("grd_busy", busy, 1);
        @(posedge clk);
        #1 cfg_we = 1'b0;
        recv(8'd32, "grd_a");
        recv(8'd48, "grd_b");
        send(32'd64, 32'd0, 1'b0, "grd_c");
        recv(8'd64, "grd_c");
        @(negedge clk);
        check("grd_count_kept", out_count, 3);
        cfg(16'd1, 5'd4, 8'd0);
        @(negedge clk);
        check("grd_count_clr", out_count, 0);
        send(32'd64, 32'd0, 1'b0, "grd_new");
        recv(8'd4, "grd_new");

        // Reset mid-stream
        cfg(16'd3, 5'd2, 8'd10);
        out_ready = 1'b0;
        send(32'd1, 32'd0, 1'b0, "mrst_a");
        send(32'd2, 32'd0, 1'b0, "mrst_b");
        send(32'd3, 32'd0, 1'b1, "mrst_c");
        #2;
        check("mrst_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        check("mrst_vld_async", out_valid, 0);
        check("mrst_busy_async", busy, 0);
        check("mrst_last_async", out_last, 0);
        check("mrst_in_ready", in_ready, 1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("mrst_no_stale", out_valid, 0);
        end
        send(32'd100, 32'd27, 1'b0, "mrst_cfg_default");
        recv(8'd127, "mrst_cfg_default");

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
